decode_hazard_ctrl: RTL and testbench

Decode-stage controller for the 5-stage RV32I pipeline. Decodes the ID instruction into the sign-extender selects (imm_src, opcode654) and an EX control word, owns the ID/EX control register, and sequences pipeline stalls, bubbles and flushes. It handles load-use hazards, taken branch/jump redirects and data-memory wait states. Sits between the IF/ID register and the ID/EX datapath register.

---
 rtl/decode_hazard_ctrl_pkg.sv | 44 ++++
 rtl/decode_hazard_ctrl_if.sv | 58 +++++
 rtl/decode_hazard_ctrl_decoder.sv | 80 ++++++++
 rtl/decode_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared decode constants, FSM states and the ID/EX control word.
// Used by main_decoder and decode_hazard_ctrl.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] IMM_I_S = 2'b00;
    localparam logic [1:0] IMM_U   = 2'b01;
    localparam logic [1:0] IMM_B   = 2'b10;
    localparam logic [1:0] IMM_J   = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int BCNT_W = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic [4:0] rd;
    } ctrl_word_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// ID-stage bus between the pipeline and the decode/hazard controller.
// DECODE_HAZARD_PERF_EN adds the performance counter outputs.
interface decode_hazard_ctrl_if
`ifdef DECODE_HAZARD_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        redirect_e;
    logic        dmem_ready;
    logic [1:0]  imm_src_d;
    logic [2:0]  opcode654_d;
    logic        illegal_d;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        valid_e;
    logic [4:0]  rd_e;
    logic        reg_write_e;
    logic        mem_read_e;
    logic        mem_write_e;
    logic        alu_src_e;
    logic        branch_e;
    logic        jump_e;
    logic        jalr_e;
    logic [1:0]  result_src_e;
`ifdef DECODE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;
`endif

    modport master (
        output instr_d, valid_d, redirect_e, dmem_ready,
        input  imm_src_d, opcode654_d, illegal_d,
        input  stall_f, stall_d, flush_d,
        input  valid_e, rd_e, reg_write_e, mem_read_e,
        input  mem_write_e, alu_src_e, branch_e,
        input  jump_e, jalr_e, result_src_e
`ifdef DECODE_HAZARD_PERF_EN
        , input stall_cnt, flush_cnt, wait_cnt
`endif
    );

    modport slave (
        input  instr_d, valid_d, redirect_e, dmem_ready,
        output imm_src_d, opcode654_d, illegal_d,
        output stall_f, stall_d, flush_d,
        output valid_e, rd_e, reg_write_e, mem_read_e,
        output mem_write_e, alu_src_e, branch_e,
        output jump_e, jalr_e, result_src_e
`ifdef DECODE_HAZARD_PERF_EN
        , output stall_cnt, flush_cnt, wait_cnt
`endif
    );

endinterface

// File: rtl/decode_hazard_ctrl_decoder.sv
// Main decoder: opcode to EX control word, immediate select, rs usage.
// Unknown opcodes decode as an all-zero bubble.
module main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [11:0] instr_i,
    input  logic        valid_i,
    output ctrl_word_t  cw_o,
    output logic [1:0]  imm_src_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o,
    output logic        illegal_o
);
    logic [6:0] op;
    assign op = instr_i[6:0];

    // Opcode decode; rd only kept for register-writing instructions
    always_comb begin
        cw_o      = '0;
        imm_src_o = IMM_I_S;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        unique case (1'b1)
            (op == OP_LOAD): begin
                cw_o.reg_write  = 1'b1;
                cw_o.mem_read   = 1'b1;
                cw_o.alu_src    = 1'b1;
                cw_o.result_src = RES_MEM;
                use_rs1_o       = 1'b1;
            end
            (op == OP_STORE): begin
                cw_o.mem_write = 1'b1;
                cw_o.alu_src   = 1'b1;
                use_rs1_o      = 1'b1;
                use_rs2_o      = 1'b1;
            end
            (op == OP_IMM): begin
                cw_o.reg_write = 1'b1;
                cw_o.alu_src   = 1'b1;
                use_rs1_o      = 1'b1;
            end
            (op == OP_OP): begin
                cw_o.reg_write = 1'b1;
                use_rs1_o      = 1'b1;
                use_rs2_o      = 1'b1;
            end
            (op == OP_LUI), (op == OP_AUIPC): begin
                cw_o.reg_write = 1'b1;
                cw_o.alu_src   = 1'b1;
                imm_src_o      = IMM_U;
            end
            (op == OP_BRANCH): begin
                cw_o.branch = 1'b1;
                imm_src_o   = IMM_B;
                use_rs1_o   = 1'b1;
                use_rs2_o   = 1'b1;
            end
            (op == OP_JAL): begin
                cw_o.reg_write  = 1'b1;
                cw_o.jump       = 1'b1;
                cw_o.result_src = RES_PC4;
                imm_src_o       = IMM_J;
            end
            (op == OP_JALR): begin
                cw_o.reg_write  = 1'b1;
                cw_o.jump       = 1'b1;
                cw_o.jalr       = 1'b1;
                cw_o.alu_src    = 1'b1;
                cw_o.result_src = RES_PC4;
                use_rs1_o       = 1'b1;
            end
            default: illegal_o = valid_i;
        endcase
        if (cw_o.reg_write) begin
            cw_o.rd = instr_i[11:7];
        end
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage controller: ID decode, ID/EX control register, stall FSM.
// Optional DECODE_HAZARD_PERF_EN adds stall/flush/wait cycle counters.
module decode_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1
`ifdef DECODE_HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
)(
    input logic                 clk,
    input logic                 rst,
    decode_hazard_ctrl_if.slave bus
);
    localparam logic [BCNT_W-1:0] BUB_INIT =
        BCNT_W'(LOAD_USE_BUBBLES - 1);

    ctrl_word_t        dec_cw;
    ctrl_word_t        ex_q;
    logic              valid_e_q;
    logic [1:0]        imm_src;
    logic              use_rs1;
    logic              use_rs2;
    logic              illegal;
    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    state_t            eff;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              hazard;
    logic              stall;
    logic              flush;
    logic              bubble;
    logic              hold;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              unused_bits;

    main_decoder u_dec (
        .instr_i   (bus.instr_d[11:0]),
        .valid_i   (bus.valid_d),
        .cw_o      (dec_cw),
        .imm_src_o (imm_src),
        .use_rs1_o (use_rs1),
        .use_rs2_o (use_rs2),
        .illegal_o (illegal)
    );

    assign rs1 = bus.instr_d[19:15];
    assign rs2 = bus.instr_d[24:20];
    assign unused_bits = ^{bus.instr_d[31:25], bus.instr_d[14:12]};

    // WAIT behaves as the saved state once memory is ready again
    assign eff = (state_q == ST_WAIT) ? ret_q : state_q;

    assign hazard = bus.valid_d & valid_e_q & ex_q.mem_read
                  & (ex_q.rd != 5'd0)
                  & ((use_rs1 & (rs1 == ex_q.rd))
                   | (use_rs2 & (rs2 == ex_q.rd)));

    // State, saved return state and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next state: memory freeze, then redirect, then load-use bubbles
    always_comb begin
        state_d = eff;
        ret_d   = ret_q;
        bcnt_d  = bcnt_q;
        if (!bus.dmem_ready) begin
            state_d = ST_WAIT;
            ret_d   = eff;
        end else if (bus.redirect_e) begin
            state_d = ST_RUN;
            bcnt_d  = '0;
        end else if (eff == ST_BUBBLE) begin
            bcnt_d = bcnt_q - BCNT_W'(1);
            if (bcnt_q <= BCNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end else if (hazard) begin
            bcnt_d = BUB_INIT;
            if (BUB_INIT != '0) begin
                state_d = ST_BUBBLE;
            end
        end
    end

    // Pipeline controls for the current cycle
    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        hold   = 1'b0;
        if (!rst) begin
            if (!bus.dmem_ready) begin
                stall = 1'b1;
                hold  = 1'b1;
            end else if (bus.redirect_e) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (eff == ST_BUBBLE || hazard) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // ID/EX control register: hold, bubble or decoded word
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            valid_e_q <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                ex_q      <= '0;
                valid_e_q <= 1'b0;
            end else begin
                ex_q      <= dec_cw;
                valid_e_q <= bus.valid_d & ~illegal;
            end
        end
    end

    assign bus.imm_src_d    = imm_src;
    assign bus.opcode654_d  = bus.instr_d[6:4];
    assign bus.illegal_d    = illegal;
    assign bus.stall_f      = stall;
    assign bus.stall_d      = stall;
    assign bus.flush_d      = flush;
    assign bus.valid_e      = valid_e_q;
    assign bus.rd_e         = ex_q.rd;
    assign bus.reg_write_e  = ex_q.reg_write;
    assign bus.mem_read_e   = ex_q.mem_read;
    assign bus.mem_write_e  = ex_q.mem_write;
    assign bus.alu_src_e    = ex_q.alu_src;
    assign bus.branch_e     = ex_q.branch;
    assign bus.jump_e       = ex_q.jump;
    assign bus.jalr_e       = ex_q.jalr;
    assign bus.result_src_e = ex_q.result_src;

`ifdef DECODE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;

    // Wrapping event counters for stalls, flushes and WAIT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (stall & bus.dmem_ready)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (state_q == ST_WAIT)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl (1- and 3-bubble instances).
// Counters are also checked when DECODE_HAZARD_PERF_EN is defined.
module tb_decode_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   sid = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl_if ifa ();
    decode_hazard_ctrl_if ifb ();

    decode_hazard_ctrl u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    decode_hazard_ctrl #(.LOAD_USE_BUBBLES(3)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    localparam logic [31:0] I_NONE = 32'h0000_0000;
    localparam logic [31:0] I_ADDI = 32'h00A0_0093;
    localparam logic [31:0] I_LW   = 32'h0000_A283;
    localparam logic [31:0] I_ADD  = 32'h0022_8333;
    localparam logic [31:0] I_LUI  = 32'h1234_53B7;
    localparam logic [31:0] I_BEQ  = 32'h0020_8063;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    // {valid, rd, rw mr mw as br jp jr, result_src}
    localparam logic [14:0] E_0    = 15'd0;
    localparam logic [14:0] E_ADDI = {1'b1, 5'd1, 7'b1001000, 2'b00};
    localparam logic [14:0] E_LW   = {1'b1, 5'd5, 7'b1101000, 2'b01};
    localparam logic [14:0] E_ADD  = {1'b1, 5'd6, 7'b1000000, 2'b00};
    localparam logic [14:0] E_LUI  = {1'b1, 5'd7, 7'b1001000, 2'b00};
    localparam logic [14:0] E_JAL  = {1'b1, 5'd1, 7'b1000010, 2'b10};
    localparam logic [14:0] E_BEQ  = {1'b1, 5'd0, 7'b0000100, 2'b00};
    localparam logic [14:0] E_SW   = {1'b1, 5'd0, 7'b0011000, 2'b00};

    // {illegal, stall_f, stall_d, flush_d}
    localparam logic [3:0] F_N  = 4'b0000;
    localparam logic [3:0] F_ST = 4'b0110;
    localparam logic [3:0] F_FL = 4'b0001;
    localparam logic [3:0] F_IL = 4'b1000;

    typedef struct packed {
        logic        ck;
        logic [8:0]  ca;
        logic [14:0] ea;
        logic [8:0]  cb;
        logic [14:0] eb;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [8:0]  ga, gb;
    logic [14:0] xa, xb;

    function automatic logic [8:0] cm(input logic [1:0] im,
                                      input logic [2:0] op,
                                      input logic [3:0] f);
        return {im, op, f};
    endfunction

    task automatic drive(input logic r, input logic [31:0] ins,
                         input logic vd, input logic rdr,
                         input logic rdy);
        rst            = r;
        ifa.instr_d    = ins;
        ifb.instr_d    = ins;
        ifa.valid_d    = vd;
        ifb.valid_d    = vd;
        ifa.redirect_e = rdr;
        ifb.redirect_e = rdr;
        ifa.dmem_ready = rdy;
        ifb.dmem_ready = rdy;
    endtask

    task automatic step2(input logic r, input logic [31:0] ins,
                         input logic vd, input logic rdr,
                         input logic rdy, input logic ck,
                         input logic [8:0] ca, input logic [14:0] ea,
                         input logic [8:0] cb, input logic [14:0] eb);
        exp_t e;
        drive(r, ins, vd, rdr, rdy);
        e.ck = ck;
        e.ca = ca;
        e.ea = ea;
        e.cb = cb;
        e.eb = eb;
        e.id = sid;
        sid++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [31:0] ins,
                        input logic vd, input logic rdr,
                        input logic rdy, input logic [8:0] c,
                        input logic [14:0] ex);
        step2(r, ins, vd, rdr, rdy, 1'b1, c, ex, c, ex);
    endtask

    // Monitor: pops one expectation per cycle, samples at negedge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            ga = {ifa.imm_src_d, ifa.opcode654_d, ifa.illegal_d,
                  ifa.stall_f, ifa.stall_d, ifa.flush_d};
            gb = {ifb.imm_src_d, ifb.opcode654_d, ifb.illegal_d,
                  ifb.stall_f, ifb.stall_d, ifb.flush_d};
            xa = {ifa.valid_e, ifa.rd_e, ifa.reg_write_e,
                  ifa.mem_read_e, ifa.mem_write_e, ifa.alu_src_e,
                  ifa.branch_e, ifa.jump_e, ifa.jalr_e,
                  ifa.result_src_e};
            xb = {ifb.valid_e, ifb.rd_e, ifb.reg_write_e,
                  ifb.mem_read_e, ifb.mem_write_e, ifb.alu_src_e,
                  ifb.branch_e, ifb.jump_e, ifb.jalr_e,
                  ifb.result_src_e};
            if (me.ck) begin
                checks += 4;
                if (ga !== me.ca) begin
                    failures++;
                    $display("FAIL idA#%0d got=%b exp=%b",
                             me.id, ga, me.ca);
                end
                if (xa !== me.ea) begin
                    failures++;
                    $display("FAIL exA#%0d got=%b exp=%b",
                             me.id, xa, me.ea);
                end
                if (gb !== me.cb) begin
                    failures++;
                    $display("FAIL idB#%0d got=%b exp=%b",
                             me.id, gb, me.cb);
                end
                if (xb !== me.eb) begin
                    failures++;
                    $display("FAIL exB#%0d got=%b exp=%b",
                             me.id, xb, me.eb);
                end
            end
        end
    end

    initial begin
        drive(1'b1, I_NONE, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        // reset 2 cycles, then addi
        step(1, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_0);
        step(1, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_0);
        step(0, I_ADDI, 1, 0, 1, cm(2'b00, 3'b001, F_N), E_0);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_ADDI);
        // lw x5 then add x6,x5,x2: 1 vs 3 bubbles
        step(0, I_LW,  1, 0, 1, cm(2'b00, 3'b000, F_N),  E_0);
        step(0, I_ADD, 1, 0, 1, cm(2'b00, 3'b011, F_ST), E_LW);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_0,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_ADD,
              cm(2'b00, 3'b011, F_N), E_0);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_ADD);
        // lw then lui: no stall
        step(0, I_LW,   1, 0, 1, cm(2'b00, 3'b000, F_N), E_0);
        step(0, I_LUI,  1, 0, 1, cm(2'b01, 3'b011, F_N), E_LW);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_LUI);
        // redirect beats load-use hazard
        step(0, I_LW,   1, 0, 1, cm(2'b00, 3'b000, F_N),  E_0);
        step(0, I_ADD,  1, 1, 1, cm(2'b00, 3'b011, F_FL), E_LW);
        step(0, I_ADD,  1, 0, 1, cm(2'b00, 3'b011, F_N),  E_0);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N),  E_ADD);
        // dmem wait for 4 cycles in BUBBLE with bcnt=1 (instance B)
        step(0, I_LW,  1, 0, 1, cm(2'b00, 3'b000, F_N),  E_0);
        step(0, I_ADD, 1, 0, 1, cm(2'b00, 3'b011, F_ST), E_LW);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_0,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 0, 1,
              cm(2'b00, 3'b011, F_ST), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 0, 1,
              cm(2'b00, 3'b011, F_ST), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 1, 0, 1,
              cm(2'b00, 3'b011, F_ST), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 0, 1,
              cm(2'b00, 3'b011, F_ST), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_ADD,
              cm(2'b00, 3'b011, F_ST), E_0);
        step2(0, I_ADD, 1, 0, 1, 1,
              cm(2'b00, 3'b011, F_N), E_ADD,
              cm(2'b00, 3'b011, F_N), E_0);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N), E_ADD);
        // immediate selects and illegal opcode
        step(0, I_JAL,  1, 0, 1, cm(2'b11, 3'b110, F_N),  E_0);
        step(0, I_BEQ,  1, 0, 1, cm(2'b10, 3'b110, F_N),  E_JAL);
        step(0, I_LUI,  1, 0, 1, cm(2'b01, 3'b011, F_N),  E_BEQ);
        step(0, I_SW,   1, 0, 1, cm(2'b00, 3'b010, F_N),  E_LUI);
        step(0, I_BAD,  1, 0, 1, cm(2'b00, 3'b111, F_IL), E_SW);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N),  E_0);
        // reset in the middle of a WAIT
        step(0, I_LW,   1, 0, 1, cm(2'b00, 3'b000, F_N),  E_0);
        step(0, I_ADD,  1, 0, 0, cm(2'b00, 3'b011, F_ST), E_LW);
        step(1, I_ADD,  1, 0, 0, cm(2'b00, 3'b011, F_N),  E_LW);
        step(0, I_ADD,  1, 0, 1, cm(2'b00, 3'b011, F_N),  E_0);
        step(0, I_NONE, 0, 0, 1, cm(2'b00, 3'b000, F_N),  E_ADD);
`ifdef DECODE_HAZARD_PERF_EN
        // 2 load-use stalls, 1 redirect, 3 WAIT cycles
        step2(1, I_NONE, 0, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_LW,   1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_ADD,  1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_ADD,  1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_LW,   1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_ADD,  1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_ADD,  1, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_ADD,  1, 1, 1, 0, '0, '0, '0, '0);
        step2(0, I_NONE, 0, 0, 0, 0, '0, '0, '0, '0);
        step2(0, I_NONE, 0, 0, 0, 0, '0, '0, '0, '0);
        step2(0, I_NONE, 0, 0, 0, 0, '0, '0, '0, '0);
        step2(0, I_NONE, 0, 0, 1, 0, '0, '0, '0, '0);
        step2(0, I_NONE, 0, 0, 1, 0, '0, '0, '0, '0);
        checks += 3;
        if (ifa.stall_cnt !== 32'd2) begin
            failures++;
            $display("FAIL stall_cnt got=%0d exp=2", ifa.stall_cnt);
        end
        if (ifa.flush_cnt !== 32'd1) begin
            failures++;
            $display("FAIL flush_cnt got=%0d exp=1", ifa.flush_cnt);
        end
        if (ifa.wait_cnt !== 32'd3) begin
            failures++;
            $display("FAIL wait_cnt got=%0d exp=3", ifa.wait_cnt);
        end
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
